cr_fifo_wrap3: RTL and testbench

CR_FIFO_WRAP3 -- requirements
Module: cr_fifo_wrap3

---
 rtl/cr_fifo_pkg.sv | 36 +++
 rtl/cr_fifo_wrap3_flags.sv | 82 ++++++++
 rtl/cr_fifo_wrap3.sv | 196 +++++++++++++++++++
 tb/tb_cr_fifo_wrap3.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_fifo_pkg.sv
// ---------------------------------------------------------------------------
// cr_fifo_pkg
//
// Shared FIFO definitions:
//   fifo_err_e    - per-cycle error event code (none / overflow / underflow)
//   fifo_flags_t  - packed bundle of the four status flags
//   cw_of()       - width of an occupancy/threshold field for a given depth,
//                   i.e. enough bits to hold the values 0..n_entries
//   sat_thr()     - clamps a threshold to the FIFO depth
// ---------------------------------------------------------------------------
package cr_fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_ERR_NONE      = 2'd0,
        FIFO_ERR_OVERFLOW  = 2'd1,
        FIFO_ERR_UNDERFLOW = 2'd2
    } fifo_err_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    // The occupancy can reach n_entries itself, hence the +1.
    function automatic int cw_of(input int n_entries);
        return $clog2(n_entries + 1);
    endfunction

    // Any threshold at or above the depth behaves the same, so clamp it.
    function automatic int sat_thr(input int thr, input int n_entries);
        return (thr > n_entries) ? n_entries : thr;
    endfunction

endpackage

// File: rtl/cr_fifo_wrap3_flags.sv
// ---------------------------------------------------------------------------
// cr_fifo_wrap3_flags
//
// Holds the almost-full / almost-empty threshold registers and produces the
// registered status flags from the FIFO's next-state occupancy, so that the
// flags always line up with the registered used_slots in the parent.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   next_used         occupancy the parent will hold after this edge
//   cfg_afull_thr     almost-full threshold to load (free slots)
//   cfg_aempty_thr    almost-empty threshold to load (used slots)
//   cfg_thr_ld        load strobe for both thresholds
//   flags             registered full / empty / afull / aempty
// ---------------------------------------------------------------------------
module cr_fifo_wrap3_flags
    import cr_fifo_pkg::*;
#(
    parameter int N_ENTRIES    = 16,
    parameter int N_AFULL_DEF  = 1,
    parameter int N_AEMPTY_DEF = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [cw_of(N_ENTRIES)-1:0]  next_used,
    input  logic [cw_of(N_ENTRIES)-1:0]  cfg_afull_thr,
    input  logic [cw_of(N_ENTRIES)-1:0]  cfg_aempty_thr,
    input  logic                         cfg_thr_ld,
    output fifo_flags_t                  flags
);

    localparam int CW = cw_of(N_ENTRIES);
    localparam logic [CW-1:0] N_CW       = CW'(N_ENTRIES);
    localparam logic [CW-1:0] AFULL_RST  = CW'(sat_thr(N_AFULL_DEF, N_ENTRIES));
    localparam logic [CW-1:0] AEMPTY_RST = CW'(sat_thr(N_AEMPTY_DEF, N_ENTRIES));

    logic [CW-1:0] afull_thr_q;
    logic [CW-1:0] aempty_thr_q;
    logic [CW-1:0] afull_thr_nxt;
    logic [CW-1:0] aempty_thr_nxt;
    fifo_flags_t   flags_nxt;

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] thr);
        return (thr > N_CW) ? N_CW : thr;
    endfunction

    // A threshold loaded on this edge becomes the active threshold from the
    // next cycle on. The flags registered on the same edge are evaluated
    // against it, so afull/aempty never disagree with the active threshold.
    always_comb begin
        afull_thr_nxt    = cfg_thr_ld ? clamp(cfg_afull_thr)  : afull_thr_q;
        aempty_thr_nxt   = cfg_thr_ld ? clamp(cfg_aempty_thr) : aempty_thr_q;
        flags_nxt.full   = (next_used == N_CW);
        flags_nxt.empty  = (next_used == '0);
        flags_nxt.afull  = ((N_CW - next_used) <= afull_thr_nxt);
        flags_nxt.aempty = (next_used <= aempty_thr_nxt);
    end

    // Threshold registers. A flush in the parent leaves these untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afull_thr_q  <= AFULL_RST;
            aempty_thr_q <= AEMPTY_RST;
        end else begin
            afull_thr_q  <= afull_thr_nxt;
            aempty_thr_q <= aempty_thr_nxt;
        end
    end

    // Flag register. Reset values correspond to an occupancy of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags.full   <= 1'b0;
            flags.empty  <= 1'b1;
            flags.afull  <= (AFULL_RST >= N_CW);
            flags.aempty <= 1'b1;
        end else begin
            flags <= flags_nxt;
        end
    end

endmodule

// File: rtl/cr_fifo_wrap3.sv
// ---------------------------------------------------------------------------
// cr_fifo_wrap3
//
// First-word-fall-through FIFO of arbitrary depth (not limited to powers of
// two) with runtime almost-full / almost-empty thresholds, sticky overflow /
// underflow flags and a synchronous flush.
//
// Build option:
//   CR_FIFO_WRAP3_STATS_EN  when defined, hwm tracks the highest occupancy
//                           seen since reset or the last clear; otherwise
//                           hwm is tied to zero.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   clear                        synchronous flush, wins over wen/ren
//   wdata, wen                   write data and request
//   ren                          pop request
//   cfg_afull_thr/aempty_thr     runtime thresholds, loaded by cfg_thr_ld
//   rdata                        head-of-queue data
//   full, empty, afull, aempty   registered status flags
//   used_slots                   registered occupancy
//   overflow_err, underflow_err  sticky error flags
//   hwm                          occupancy high-water mark
// ---------------------------------------------------------------------------
module cr_fifo_wrap3
    import cr_fifo_pkg::*;
#(
    parameter int N_DATA_BITS  = 64,
    parameter int N_ENTRIES    = 16,
    parameter int N_AFULL_DEF  = 1,
    parameter int N_AEMPTY_DEF = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [N_DATA_BITS-1:0]       wdata,
    input  logic                         wen,
    input  logic                         ren,
    input  logic [cw_of(N_ENTRIES)-1:0]  cfg_afull_thr,
    input  logic [cw_of(N_ENTRIES)-1:0]  cfg_aempty_thr,
    input  logic                         cfg_thr_ld,
    output logic [N_DATA_BITS-1:0]       rdata,
    output logic                         full,
    output logic                         empty,
    output logic                         afull,
    output logic                         aempty,
    output logic [cw_of(N_ENTRIES)-1:0]  used_slots,
    output logic                         overflow_err,
    output logic                         underflow_err,
    output logic [cw_of(N_ENTRIES)-1:0]  hwm
);

    localparam int CW = cw_of(N_ENTRIES);
    localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_ENTRIES - 1);

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic                   wr_acc;
    logic                   rd_acc;
    logic [CW-1:0]          used_nxt;
    fifo_err_e              err_evt;
    fifo_flags_t            flags;

    // Pointers step through 0..N_ENTRIES-1 and wrap explicitly, which keeps
    // non-power-of-two depths correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + PW'(1);
    endfunction

    // Acceptance is judged against the registered flags, so a write into a
    // full FIFO is dropped even if a pop happens in the same cycle.
    always_comb begin
        wr_acc = wen && !full  && !clear;
        rd_acc = ren && !empty && !clear;
    end

    // Next-state occupancy, shared with the flag generator.
    always_comb begin
        used_nxt = used_slots;
        if (clear) begin
            used_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            used_nxt = used_slots + CW'(1);
        end else if (!wr_acc && rd_acc) begin
            used_nxt = used_slots - CW'(1);
        end
    end

    // Classify this cycle's rejected request, if any. Full and empty are
    // mutually exclusive for a depth of two or more.
    always_comb begin
        err_evt = FIFO_ERR_NONE;
        if (!clear) begin
            if (wen && full) begin
                err_evt = FIFO_ERR_OVERFLOW;
            end else if (ren && empty) begin
                err_evt = FIFO_ERR_UNDERFLOW;
            end
        end
    end

    // Storage. Contents are zeroed on reset so rdata reads zero before the
    // first write; a flush only moves the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            used_slots <= '0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            used_slots <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_acc) begin
                rptr <= ptr_inc(rptr);
            end
            used_slots <= used_nxt;
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (clear) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (err_evt == FIFO_ERR_OVERFLOW) begin
                overflow_err <= 1'b1;
            end
            if (err_evt == FIFO_ERR_UNDERFLOW) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Head of queue is presented combinationally from the read pointer.
    assign rdata = mem[rptr];

    cr_fifo_wrap3_flags #(
        .N_ENTRIES    (N_ENTRIES),
        .N_AFULL_DEF  (N_AFULL_DEF),
        .N_AEMPTY_DEF (N_AEMPTY_DEF)
    ) u_flags (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_used      (used_nxt),
        .cfg_afull_thr  (cfg_afull_thr),
        .cfg_aempty_thr (cfg_aempty_thr),
        .cfg_thr_ld     (cfg_thr_ld),
        .flags          (flags)
    );

    assign full   = flags.full;
    assign empty  = flags.empty;
    assign afull  = flags.afull;
    assign aempty = flags.aempty;

`ifdef CR_FIFO_WRAP3_STATS_EN
    logic [CW-1:0] hwm_q;

    // High-water mark follows the registered occupancy, one cycle behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else if (clear) begin
            hwm_q <= '0;
        end else if (used_slots > hwm_q) begin
            hwm_q <= used_slots;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_cr_fifo_wrap3.sv
// ---------------------------------------------------------------------------
// tb_cr_fifo_wrap3
//
// Self-checking bench for cr_fifo_wrap3. An 8-deep instance runs a table of
// per-cycle vectors with expected occupancy and flags, while a data queue
// holds the words that should come out. A 6-deep instance exercises pointer
// wrap at a non-power-of-two depth, plus the full boundary.
// ---------------------------------------------------------------------------
module tb_cr_fifo_wrap3;

    localparam int DW  = 64;
    localparam int CW8 = 4;
    localparam int CW6 = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // 8-deep instance
    logic           clear8;
    logic [DW-1:0]  wdata8;
    logic           wen8;
    logic           ren8;
    logic [CW8-1:0] afthr8;
    logic [CW8-1:0] aethr8;
    logic           ld8;
    logic [DW-1:0]  rdata8;
    logic           full8, empty8, afull8, aempty8;
    logic [CW8-1:0] used8;
    logic           ovf8, udf8;
    logic [CW8-1:0] hwm8;

    // 6-deep instance
    logic           clear6;
    logic [DW-1:0]  wdata6;
    logic           wen6;
    logic           ren6;
    logic [CW6-1:0] afthr6;
    logic [CW6-1:0] aethr6;
    logic           ld6;
    logic [DW-1:0]  rdata6;
    logic           full6, empty6, afull6, aempty6;
    logic [CW6-1:0] used6;
    logic           ovf6, udf6;
    logic [CW6-1:0] hwm6;

    cr_fifo_wrap3 #(
        .N_DATA_BITS (DW),
        .N_ENTRIES   (8)
    ) dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear8),
        .wdata          (wdata8),
        .wen            (wen8),
        .ren            (ren8),
        .cfg_afull_thr  (afthr8),
        .cfg_aempty_thr (aethr8),
        .cfg_thr_ld     (ld8),
        .rdata          (rdata8),
        .full           (full8),
        .empty          (empty8),
        .afull          (afull8),
        .aempty         (aempty8),
        .used_slots     (used8),
        .overflow_err   (ovf8),
        .underflow_err  (udf8),
        .hwm            (hwm8)
    );

    cr_fifo_wrap3 #(
        .N_DATA_BITS (DW),
        .N_ENTRIES   (6)
    ) dut6 (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear6),
        .wdata          (wdata6),
        .wen            (wen6),
        .ren            (ren6),
        .cfg_afull_thr  (afthr6),
        .cfg_aempty_thr (aethr6),
        .cfg_thr_ld     (ld6),
        .rdata          (rdata6),
        .full           (full6),
        .empty          (empty6),
        .afull          (afull6),
        .aempty         (aempty6),
        .used_slots     (used6),
        .overflow_err   (ovf6),
        .underflow_err  (udf6),
        .hwm            (hwm6)
    );

    typedef struct {
        logic           wen;
        logic           ren;
        logic           clr;
        logic           ld;
        logic [CW8-1:0] afthr;
        logic [CW8-1:0] aethr;
        logic [DW-1:0]  wdata;
        int             used;
        logic           chk_flags;
        logic           full;
        logic           empty;
        logic           afull;
        logic           aempty;
        logic           ovf;
        logic           udf;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic vec_t mk(input int wen, input int ren, input int clr, input int ld,
                                input int afthr, input int aethr, input logic [DW-1:0] wdata,
                                input int used, input int chk, input int full, input int empty,
                                input int afull, input int aempty, input int ovf, input int udf);
        vec_t v;
        v.wen       = (wen != 0);
        v.ren       = (ren != 0);
        v.clr       = (clr != 0);
        v.ld        = (ld != 0);
        v.afthr     = CW8'(afthr);
        v.aethr     = CW8'(aethr);
        v.wdata     = wdata;
        v.used      = used;
        v.chk_flags = (chk != 0);
        v.full      = (full != 0);
        v.empty     = (empty != 0);
        v.afull     = (afull != 0);
        v.aempty    = (aempty != 0);
        v.ovf       = (ovf != 0);
        v.udf       = (udf != 0);
        return v;
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        wen8   = v.wen;
        ren8   = v.ren;
        clear8 = v.clr;
        ld8    = v.ld;
        afthr8 = v.afthr;
        aethr8 = v.aethr;
        wdata8 = v.wdata;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   prev_used;
        logic wr_ok;
        logic rd_ok;
        logic [DW-1:0] exp_hwm;

        rst_n  = 1'b0;
        clear8 = 1'b0; wdata8 = '0; wen8 = 1'b0; ren8 = 1'b0;
        afthr8 = '0;   aethr8 = '0; ld8  = 1'b0;
        clear6 = 1'b0; wdata6 = '0; wen6 = 1'b0; ren6 = 1'b0;
        afthr6 = '0;   aethr6 = '0; ld6  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_used",   64'(used8),   64'(0));
        check_output("rst_empty",  64'(empty8),  64'(1));
        check_output("rst_full",   64'(full8),   64'(0));
        check_output("rst_afull",  64'(afull8),  64'(0));
        check_output("rst_aempty", 64'(aempty8), 64'(1));
        check_output("rst_ovf",    64'(ovf8),    64'(0));
        check_output("rst_udf",    64'(udf8),    64'(0));
        check_output("rst_rdata",  rdata8,       64'(0));
        check_output("rst_hwm",    64'(hwm8),    64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Thresholds default to 1: afull when used >= 7, aempty when used <= 1.
        vecs.push_back(mk(1,1,0,0,0,0,64'hA1,   1,1, 0,0,0,1, 0,1));
        vecs.push_back(mk(0,1,0,0,0,0,64'h0,    0,1, 0,1,0,1, 0,1));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(1,0,0,0,0,0,64'h10 + 64'(k), k+1,1,
                              int'(k+1 == 8), 0, int'(k+1 >= 7), int'(k+1 <= 1), 0,1));
        end
        vecs.push_back(mk(1,1,0,0,0,0,64'hEE,   7,1, 0,0,1,0, 1,1));
        vecs.push_back(mk(1,0,0,0,0,0,64'h18,   8,1, 1,0,1,0, 1,1));
        vecs.push_back(mk(0,1,0,0,0,0,64'h0,    7,1, 0,0,1,0, 1,1));
        vecs.push_back(mk(0,1,0,0,0,0,64'h0,    6,1, 0,0,0,0, 1,1));
        vecs.push_back(mk(0,1,0,0,0,0,64'h0,    5,1, 0,0,0,0, 1,1));
        vecs.push_back(mk(1,0,1,0,0,0,64'h99,   0,1, 0,1,0,1, 0,0));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(1,0,0,0,0,0,64'h20 + 64'(k), k+1,1,
                              0, 0, 0, int'(k+1 <= 1), 0,0));
        end
        vecs.push_back(mk(0,0,0,1,4,3,64'h0,    4,0, 0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,64'h0,    4,1, 0,0,1,0, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0,64'h0,    3,1, 0,0,0,1, 0,0));
        vecs.push_back(mk(0,0,0,1,15,12,64'h0,  3,0, 0,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,64'h0,    3,1, 0,0,1,1, 0,0));
        vecs.push_back(mk(0,1,0,0,0,0,64'h0,    2,1, 0,0,1,1, 0,0));
        vecs.push_back(mk(1,0,0,0,0,0,64'h30,   3,1, 0,0,1,1, 0,0));

        prev_used = 0;
        foreach (vecs[i]) begin
            wr_ok = vecs[i].wen && !vecs[i].clr && (prev_used < 8);
            rd_ok = vecs[i].ren && !vecs[i].clr && (prev_used > 0);
            if (rd_ok) begin
                check_output($sformatf("row%0d_pop_data", i), rdata8, sb.pop_front());
            end
            apply_stimulus(vecs[i]);
            @(posedge clk);
            #1;
            if (vecs[i].clr) begin
                sb.delete();
            end
            if (wr_ok) begin
                sb.push_back(vecs[i].wdata);
            end
            check_output($sformatf("row%0d_used", i), 64'(used8), 64'(vecs[i].used));
            if (vecs[i].chk_flags) begin
                check_output($sformatf("row%0d_full", i),   64'(full8),   64'(vecs[i].full));
                check_output($sformatf("row%0d_empty", i),  64'(empty8),  64'(vecs[i].empty));
                check_output($sformatf("row%0d_afull", i),  64'(afull8),  64'(vecs[i].afull));
                check_output($sformatf("row%0d_aempty", i), 64'(aempty8), 64'(vecs[i].aempty));
            end
            check_output($sformatf("row%0d_ovf", i), 64'(ovf8), 64'(vecs[i].ovf));
            check_output($sformatf("row%0d_udf", i), 64'(udf8), 64'(vecs[i].udf));
            if (sb.size() > 0) begin
                check_output($sformatf("row%0d_head", i), rdata8, sb[0]);
            end
            if (vecs[i].clr) begin
                check_output($sformatf("row%0d_hwm_clr", i), 64'(hwm8), 64'(0));
            end
            prev_used = vecs[i].used;
        end
        wen8 = 1'b0; ren8 = 1'b0; clear8 = 1'b0; ld8 = 1'b0;

        // Wrap test on the 6-deep instance: 20 write-then-pop pairs.
        sb.delete();
        for (int i = 0; i < 20; i++) begin
            logic [DW-1:0] d;
            d = {$urandom(), $urandom()};
            sb.push_back(d);
            wdata6 = d; wen6 = 1'b1; ren6 = 1'b0;
            @(posedge clk);
            #1;
            check_output($sformatf("wrap%0d_data", i), rdata6, sb.pop_front());
            check_output($sformatf("wrap%0d_used1", i), 64'(used6), 64'(1));
            wen6 = 1'b0; ren6 = 1'b1;
            @(posedge clk);
            #1;
            check_output($sformatf("wrap%0d_used0", i), 64'(used6), 64'(0));
            check_output($sformatf("wrap%0d_empty", i), 64'(empty6), 64'(1));
        end
        ren6 = 1'b0;
`ifdef CR_FIFO_WRAP3_STATS_EN
        exp_hwm = 64'(1);
`else
        exp_hwm = 64'(0);
`endif
        check_output("wrap_hwm", 64'(hwm6), exp_hwm);

        // Fill the 6-deep instance to its boundary, then overflow it.
        for (int k = 0; k < 6; k++) begin
            wdata6 = 64'(k + 100); wen6 = 1'b1;
            @(posedge clk);
            #1;
            check_output($sformatf("fill%0d_used", k), 64'(used6), 64'(k + 1));
            check_output($sformatf("fill%0d_full", k), 64'(full6), 64'(k == 5));
        end
        wdata6 = 64'hDEAD;
        @(posedge clk);
        #1;
        wen6 = 1'b0;
        check_output("fill_ovf",   64'(ovf6),  64'(1));
        check_output("fill_used",  64'(used6), 64'(6));
        check_output("fill_head",  rdata6,     64'(100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
